right_shifter_seq: RTL and testbench
====================================

# right_shifter_seq

Multi-cycle right-shift unit for the 8-bit single-cycle processor datapath, complementing the combinational left-shift path. It performs logical, arithmetic, or rotate right shifts of an 8-bit operand, one bit position per clock, under a start/busy/done handshake. The ALU control issues a request and waits for `DONE`, then reads `RESULT`. The unit is used for the processor's `srl`/`sra`/`ror` instructions.

## Interface
- No parameters; datapath width fixed at 8 bits.
- `CLK` input 1: single clock; all state updates on rising edge.
- `RESET` input 1: synchronous, active-low reset, sampled on rising `CLK`.
- `START` input 1: request strobe; accepted only in IDLE.
- `VALUE` input 8: operand to shift; captured when `START` is accepted.
- `AMOUNT` input 8: shift count; captured when `START` is accepted.
- `SHIFT_TYPE` input 2: shift mode; captured when `START` is accepted.
  - 00: logical right.
  - 01: arithmetic right.
  - 10: rotate right.
  - 11: reserved, executes as logical right.
- `BUSY` output 1: high while shifting.
- `DONE` output 1: one-cycle pulse when `RESULT` is valid.
- `RESULT` output 8: shifted value; holds until the next completion or reset.
- `ZERO` output 1: high when `RESULT` == 0; registered with `RESULT`.

## Operation
- Three states: IDLE, SHIFT, FINISH.
- Outputs by state:
  - `BUSY` = 1 only in SHIFT.
  - `DONE` = 1 only in FINISH.
- Internal registers: 8-bit working register `SR`, 4-bit down-counter `CNT`, 2-bit captured mode.
- IDLE with `START`=1 at an edge:
  - `SR` <= `VALUE`; mode <= `SHIFT_TYPE`.
  - `CNT` <= effective count N.
  - Next state is SHIFT if N > 0, otherwise FINISH.
- IDLE with `START`=0: remain in IDLE.
- Effective count N:
  - Logical and arithmetic modes: N = min(`AMOUNT`, 8), so N saturates at 8.
  - Rotate mode: N = `AMOUNT[2:0]`.
- SHIFT, each edge:
  - Logical: `SR` <= {0, `SR[7:1]`}.
  - Arithmetic: `SR` <= {`SR[7]`, `SR[7:1]`}.
  - Rotate: `SR` <= {`SR[0]`, `SR[7:1]`}.
  - `CNT` <= `CNT` − 1.
  - If `CNT` == 1 before the edge, the next state is FINISH, and `RESULT` <= shifted value and `ZERO` is updated at that same edge.
- FINISH to IDLE at the next edge, unconditionally.
  - For N = 0, `RESULT` <= `VALUE` and `ZERO` is updated at the IDLE→FINISH edge.
- `START` is ignored in SHIFT and FINISH (no queuing). It is not accepted in FINISH, so back-to-back requests have one idle cycle of spacing minimum.
- Input changes after capture have no effect on the operation in progress.
- Saturation results:
  - Logical shift by ≥8 yields 8'h00.
  - Arithmetic shift by ≥8 yields {8{`VALUE[7]`}}.
- `RESULT` and `ZERO` change only at completion or reset; they are stable in all other cycles.

## Timing
- Edge numbering: the capturing edge is edge 0; `DONE` is high in the cycle after edge N.
- Latency: N+1 edges from the `START` capture to `DONE` visibility.
  - Maximum is 9 edges (logical/arithmetic with N = 8).
  - Minimum is 1 edge (N = 0).
- `BUSY` is high from after edge 0 through edge N (N cycles). It is never high when N = 0.
- `DONE` stays high for exactly one cycle.
- Reset (`RESET`=0 at an edge) takes priority over everything:
  - State → IDLE.
  - `BUSY`=0, `DONE`=0, `RESULT`=8'h00, `ZERO`=1, `SR`=0, `CNT`=0.
- Reset mid-SHIFT aborts the operation with no `DONE` pulse.
- `START` sampled in the same cycle that `RESET`=0 is ignored.
- After reset release, the first accepted `START` behaves normally.

## Test plan
- Logical: `VALUE`=8'hB4, `AMOUNT`=3, `SHIFT_TYPE`=00 → `BUSY` high for 3 cycles, `DONE` after edge 3, `RESULT`=8'h16, `ZERO`=0.
- Arithmetic and rotate:
  - 8'hB4, `AMOUNT`=3, type 01 → `RESULT`=8'hF6.
  - Same operand, type 10 → `RESULT`=8'h96.
  - Type 10 with `AMOUNT`=11 → `RESULT`=8'h96, `DONE` after edge 3.
- Saturation: 8'h80, `AMOUNT`=200:
  - Type 01 → `RESULT`=8'hFF, `DONE` after edge 8.
  - Type 00 → `RESULT`=8'h00, `ZERO`=1.
  - Type 11 behaves identically to type 00.
- Zero count: 8'h5A, `AMOUNT`=0, any type → `BUSY` never high, `DONE` after edge 0, `RESULT`=8'h5A.
- Handshake:
  - `START` pulsed while `BUSY`, and in the FINISH cycle, with different `VALUE` → ignored; the first result completes unchanged.
  - Inputs changed mid-shift → no effect.
  - `DONE` is exactly one cycle wide.
- Reset: `RESET`=0 at edge 2 of an `AMOUNT`=5 operation → next cycle shows `BUSY`=0, `DONE`=0, `RESULT`=8'h00, `ZERO`=1, with no later `DONE`. A new `START` after release completes correctly.

Source files
------------

// File: rtl/right_shifter_seq.sv
// Multi-cycle right shifter (logical / arithmetic / rotate), one bit per clock,
// driven by a START/BUSY/DONE handshake from the ALU control.
module right_shifter_seq (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] VALUE,
    input  logic [7:0] AMOUNT,
    input  logic [1:0] SHIFT_TYPE,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RESULT,
    output logic       ZERO,
    output logic [1:0] state_dbg
);

    // Handshake: START is a request taken only in IDLE (treat BUSY|DONE as
    // "not ready"); DONE is a one-cycle valid for RESULT/ZERO, which then hold.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  sr;
    logic [3:0]  cnt;
    logic [1:0]  mode;
    logic [3:0]  eff_n;
    logic [7:0]  shifted;

    assign state_dbg = state;

    // Rotate wraps modulo 8; the other modes saturate at 8 since every bit is gone.
    always_comb begin
        eff_n = 4'd0;
        if (SHIFT_TYPE == 2'b10)
            eff_n = {1'b0, AMOUNT[2:0]};
        else if (AMOUNT >= 8'd8)
            eff_n = 4'd8;
        else
            eff_n = AMOUNT[3:0];
    end

    always_comb begin
        shifted = {1'b0, sr[7:1]};
        case (mode)
            2'b01:   shifted = {sr[7], sr[7:1]};
            2'b10:   shifted = {sr[0], sr[7:1]};
            default: shifted = {1'b0, sr[7:1]};
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= IDLE;
            sr     <= 8'h00;
            cnt    <= 4'd0;
            mode   <= 2'b00;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            RESULT <= 8'h00;
            ZERO   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        sr   <= VALUE;
                        mode <= SHIFT_TYPE;
                        cnt  <= eff_n;
                        if (eff_n != 4'd0) begin
                            state <= SHIFT;
                            BUSY  <= 1'b1;
                        end else begin
                            state  <= FINISH;
                            DONE   <= 1'b1;
                            RESULT <= VALUE;
                            ZERO   <= (VALUE == 8'h00);
                        end
                    end
                end
                SHIFT: begin
                    sr  <= shifted;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state  <= FINISH;
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        RESULT <= shifted;
                        ZERO   <= (shifted == 8'h00);
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_right_shifter_seq.sv
// Directed bench for right_shifter_seq: hand-computed vectors, immediate
// assertions at each check, one summary line at the end.
module tb_right_shifter_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] value;
    logic [7:0] amount;
    logic [1:0] shift_type;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       zero;
    logic [1:0] state_dbg;

    int n_cmp;
    int n_fail;
    logic [7:0] last_result;

    right_shifter_seq dut (
        .CLK        (clk),
        .RESET      (reset),
        .START      (start),
        .VALUE      (value),
        .AMOUNT     (amount),
        .SHIFT_TYPE (shift_type),
        .BUSY       (busy),
        .DONE       (done),
        .RESULT     (result),
        .ZERO       (zero),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a request so it is captured at the next rising edge (edge 0).
    task automatic start_op(input logic [7:0] v, input logic [7:0] a, input logic [1:0] t);
        @(negedge clk);
        value      = v;
        amount     = a;
        shift_type = t;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Watch from the cycle after edge 0 until DONE; optionally hammer START
    // with a different operand while busy and through the FINISH cycle.
    task automatic wait_done(input string tag, input int exp_n, input logic [7:0] exp_res,
                             input logic exp_zero, input bit disturb);
        int c;
        int busy_cnt;
        bit seen;
        busy_cnt = 0;
        seen = 0;
        c = 0;
        while (c < 20 && !seen) begin
            @(negedge clk);
            if (disturb) begin
                start      = 1'b1;
                value      = 8'hFF;
                amount     = 8'd0;
                shift_type = 2'b01;
            end
            if (done) begin
                seen = 1;
            end else begin
                if (busy) busy_cnt++;
                check({tag, "_hold"}, {8'h0, result}, {8'h0, last_result});
                c++;
            end
        end
        check({tag, "_latency"}, c[15:0], exp_n[15:0]);
        check({tag, "_busy_cycles"}, busy_cnt[15:0], exp_n[15:0]);
        check({tag, "_busy_in_done"}, {15'h0, busy}, 16'h0);
        check({tag, "_result"}, {8'h0, result}, {8'h0, exp_res});
        check({tag, "_zero"}, {15'h0, zero}, {15'h0, exp_zero});
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_width"}, {15'h0, done}, 16'h0);
        check({tag, "_idle_busy"}, {15'h0, busy}, 16'h0);
        last_result = exp_res;
    endtask

    task automatic run_op(input string tag, input logic [7:0] v, input logic [7:0] a,
                          input logic [1:0] t, input int exp_n, input logic [7:0] exp_res,
                          input logic exp_zero);
        start_op(v, a, t);
        wait_done(tag, exp_n, exp_res, exp_zero, 1'b0);
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        last_result = 8'h00;
        reset       = 1'b0;
        start       = 1'b0;
        value       = 8'h00;
        amount      = 8'h00;
        shift_type  = 2'b00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",   {15'h0, busy}, 16'h0);
        check("rst_done",   {15'h0, done}, 16'h0);
        check("rst_result", {8'h0, result}, 16'h0000);
        check("rst_zero",   {15'h0, zero}, 16'h1);
        check("rst_state",  {14'h0, state_dbg}, 16'h0);
        reset = 1'b1;

        // Main modes on 8'hB4 (1011_0100)
        run_op("srl3", 8'hB4, 8'd3, 2'b00, 3, 8'h16, 1'b0);
        run_op("sra3", 8'hB4, 8'd3, 2'b01, 3, 8'hF6, 1'b0);
        run_op("ror3", 8'hB4, 8'd3, 2'b10, 3, 8'h96, 1'b0);
        run_op("ror11", 8'hB4, 8'd11, 2'b10, 3, 8'h96, 1'b0);
        run_op("ror8", 8'hB4, 8'd8, 2'b10, 0, 8'hB4, 1'b0);
        run_op("sra1", 8'hC3, 8'd1, 2'b01, 1, 8'hE1, 1'b0);
        run_op("sra7", 8'h80, 8'd7, 2'b01, 7, 8'hFF, 1'b0);

        // Saturation
        run_op("sra200", 8'h80, 8'd200, 2'b01, 8, 8'hFF, 1'b0);
        run_op("srl200", 8'h80, 8'd200, 2'b00, 8, 8'h00, 1'b1);
        run_op("rsv200", 8'h80, 8'd200, 2'b11, 8, 8'h00, 1'b1);
        run_op("srl8",   8'hFF, 8'd8,   2'b00, 8, 8'h00, 1'b1);

        // Zero count
        run_op("zc_srl", 8'h5A, 8'd0, 2'b00, 0, 8'h5A, 1'b0);
        run_op("zc_sra", 8'h5A, 8'd0, 2'b01, 0, 8'h5A, 1'b0);
        run_op("zc_ror", 8'h5A, 8'd0, 2'b10, 0, 8'h5A, 1'b0);

        // START and operand changes while busy and in FINISH are ignored
        start_op(8'hB4, 8'd3, 2'b00);
        wait_done("ignore", 3, 8'h16, 1'b0, 1'b1);
        @(negedge clk);
        check("ignore_no_accept", {15'h0, busy | done}, 16'h0);

        // Reset at edge 2 of a 5-step operation
        start_op(8'hF0, 8'd5, 2'b00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        value = 8'h33;
        @(negedge clk);
        check("midrst_busy",   {15'h0, busy}, 16'h0);
        check("midrst_done",   {15'h0, done}, 16'h0);
        check("midrst_result", {8'h0, result}, 16'h0000);
        check("midrst_zero",   {15'h0, zero}, 16'h1);
        start = 1'b0;
        reset = 1'b1;
        last_result = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_no_done", {15'h0, done | busy}, 16'h0);
        end

        run_op("post_rst", 8'hF0, 8'd5, 2'b01, 5, 8'hFF, 1'b0);
        run_op("post_rst2", 8'h01, 8'd1, 2'b00, 1, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
